// File: rtl/dd_pkg.sv
// Shared constants for the dark-frame decider: BT.601-style luma weights,
// RGB field positions and the inversion mode encodings.
package dd_pkg;

    localparam int unsigned COEF_R     = 77;
    localparam int unsigned COEF_G     = 150;
    localparam int unsigned COEF_B     = 29;
    localparam int unsigned LUMA_SHIFT = 8;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_NEVER  = 2'b01,
        MODE_ALWAYS = 2'b10,
        MODE_AUTO_X = 2'b11
    } mode_e;

    // Manual override wins; both auto encodings follow the measured decision.
    function automatic logic eff_invert(input logic [1:0] mode, input logic inv);
        case (mode)
            MODE_NEVER:  return 1'b0;
            MODE_ALWAYS: return 1'b1;
            default:     return inv;
        endcase
    endfunction

endpackage

// File: rtl/dark_decider_if.sv
// Video sync/pixel bundle between the frame delayer, the decider and the TX path.
interface dark_decider_if;
    logic        vs_i;
    logic        hs_i;
    logic        de_i;
    logic [23:0] live_i;
    logic [23:0] dly_i;
    logic [1:0]  mode_i;
    logic        vs_o;
    logic        hs_o;
    logic        de_o;
    logic [23:0] data_o;
    logic        dark_o;

    modport slave (
        input  vs_i, hs_i, de_i, live_i, dly_i, mode_i,
        output vs_o, hs_o, de_o, data_o, dark_o
    );

    modport master (
        output vs_i, hs_i, de_i, live_i, dly_i, mode_i,
        input  vs_o, hs_o, de_o, data_o, dark_o
    );
endinterface

// File: rtl/luma_calc.sv
// Two-stage pipelined RGB-to-Y (8-bit). flush_i drops anything in flight.
module luma_calc
    import dd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [23:0] rgb_i,
    output logic        valid_o,
    output logic [7:0]  y_o
);
    localparam int STAGES = 2;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;
    logic [15:0]     p_r, p_g, p_b;
    logic [17:0]     y_sum;

    assign vld_pipe = {vld_q, valid_i};
    // Weights sum to 256, so white lands exactly on 255 after the shift.
    assign y_sum    = 18'(p_r) + 18'(p_g) + 18'(p_b);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            p_r   <= '0;
            p_g   <= '0;
            p_b   <= '0;
            y_o   <= '0;
        end else begin
            vld_q <= flush_i ? '0 : vld_pipe[STAGES-1:0];
            p_r   <= 16'(COEF_R) * 16'(rgb_i[R_MSB:R_LSB]);
            p_g   <= 16'(COEF_G) * 16'(rgb_i[G_MSB:G_LSB]);
            p_b   <= 16'(COEF_B) * 16'(rgb_i[B_MSB:B_LSB]);
            y_o   <= 8'(y_sum >> LUMA_SHIFT);
        end
    end

    assign valid_o = vld_pipe[STAGES];
endmodule

// File: rtl/dark_decider.sv
// Measures mean luma of the live frame and, at the next vsync, decides whether
// to invert the delayed copy of that frame on its way to the HDMI transmitter.
module dark_decider
    import dd_pkg::*;
#(
    parameter int unsigned H_WIDTH  = 1920,
    parameter int unsigned V_HEIGHT = 1080,
    parameter logic [7:0]  THRES_HI = 8'd160,
    parameter logic [7:0]  THRES_LO = 8'd96,
    parameter int unsigned ACC_W    = 32
) (
    input logic           clk_i,
    input logic           rst_ni,
    dark_decider_if.slave bus
);
    localparam int unsigned PIX_MAX = H_WIDTH * V_HEIGHT;
    localparam int unsigned CNT_W   = $clog2(PIX_MAX + 1);
    localparam int unsigned XW      = ACC_W + 8;

    logic             vs_r, vs_rise;
    logic             y_vld;
    logic [7:0]       y;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             inv, inv_eff;
    logic [XW-1:0]    sum_x, hi_x, lo_x;

    assign vs_rise = ~vs_r & bus.vs_i;

    luma_calc u_luma (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (vs_rise),
        .valid_i (bus.de_i),
        .rgb_i   (bus.live_i),
        .valid_o (y_vld),
        .y_o     (y)
    );

    // Mean-vs-threshold without division: compare sum against thres*cnt.
    assign sum_x = XW'(sum);
    assign hi_x  = XW'(THRES_HI) * XW'(cnt);
    assign lo_x  = XW'(THRES_LO) * XW'(cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_r <= 1'b0;
            sum  <= '0;
            cnt  <= '0;
            inv  <= 1'b0;
        end else begin
            vs_r <= bus.vs_i;
            if (vs_rise) begin
                sum <= '0;
                cnt <= '0;
                if (cnt != '0) begin
                    if (sum_x > hi_x)      inv <= 1'b1;
                    else if (sum_x < lo_x) inv <= 1'b0;
                end
            end else if (y_vld && cnt != CNT_W'(PIX_MAX)) begin
                sum <= sum + ACC_W'(y);
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign inv_eff = eff_invert(bus.mode_i, inv);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.vs_o   <= 1'b0;
            bus.hs_o   <= 1'b0;
            bus.de_o   <= 1'b0;
            bus.data_o <= '0;
        end else begin
            bus.vs_o   <= bus.vs_i;
            bus.hs_o   <= bus.hs_i;
            bus.de_o   <= bus.de_i;
            bus.data_o <= bus.de_i ? (inv_eff ? ~bus.dly_i : bus.dly_i) : 24'h0;
        end
    end

    assign bus.dark_o = inv;
endmodule

// File: tb/tb_dark_decider.sv
// Directed bench for dark_decider: 8x4 frames, 4-cycle blanking, hand-computed
// expectations for the decision, the hysteresis band, manual modes and reset.
module tb_dark_decider;
    import dd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dark_decider_if bus();

    dark_decider #(.H_WIDTH(8), .V_HEIGHT(4)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.vs_i   = 1'b0;
        bus.hs_i   = 1'b0;
        bus.de_i   = 1'b0;
        bus.live_i = 24'h0;
        bus.dly_i  = 24'h0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".vs_o"},   32'(bus.vs_o),   32'h0);
        chk({tag, ".hs_o"},   32'(bus.hs_o),   32'h0);
        chk({tag, ".de_o"},   32'(bus.de_o),   32'h0);
        chk({tag, ".data_o"}, 32'(bus.data_o), 32'h0);
        chk({tag, ".dark_o"}, 32'(bus.dark_o), 32'h0);
    endtask

    // One frame: vsync pulse, 4 blank cycles, then 4 lines of 8 pixels + 4 blank.
    task automatic run_frame(input string tag, input logic [23:0] live,
                             input logic [23:0] dly, input logic [23:0] exp_data,
                             input logic exp_dark);
        bus.vs_i = 1'b1;
        bus.de_i = 1'b0;
        cycle();
        bus.vs_i = 1'b0;
        repeat (4) cycle();
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin
                bus.hs_i   = 1'b0;
                bus.de_i   = 1'b1;
                bus.live_i = live;
                bus.dly_i  = dly;
                cycle();
                if (l == 0 && p == 0) begin
                    chk({tag, ".first"}, 32'(bus.data_o), 32'(exp_data));
                    chk({tag, ".de_o"},  32'(bus.de_o),   32'h1);
                end
                if (l == 3 && p == 7)
                    chk({tag, ".last"}, 32'(bus.data_o), 32'(exp_data));
            end
            bus.de_i   = 1'b0;
            bus.live_i = 24'h0;
            bus.dly_i  = 24'h0;
            bus.hs_i   = 1'b1;
            cycle();
            if (l == 0)
                chk({tag, ".blank"}, 32'(bus.data_o), 32'h0);
            bus.hs_i = 1'b0;
            repeat (3) cycle();
        end
        chk({tag, ".dark"}, 32'(bus.dark_o), 32'(exp_dark));
    endtask

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] GREY  = 24'h808080;

    initial begin
        // Busy inputs during reset must not reach the outputs.
        bus.mode_i = MODE_AUTO;
        bus.vs_i   = 1'b1;
        bus.hs_i   = 1'b1;
        bus.de_i   = 1'b1;
        bus.live_i = WHITE;
        bus.dly_i  = WHITE;
        repeat (3) cycle();
        chk_outputs_zero("reset");
        idle();
        cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        run_frame("f1_first", WHITE, 24'h123456, 24'h123456, 1'b0);
        run_frame("f2_white", BLACK, 24'h123456, 24'hEDCBA9, 1'b1);
        run_frame("f3_black", GREY,  24'h123456, 24'h123456, 1'b0);
        run_frame("f4_hold0", WHITE, 24'hABCDEF, 24'hABCDEF, 1'b0);
        run_frame("f5_white", GREY,  24'h0F0F0F, 24'hF0F0F0, 1'b1);
        run_frame("f6_hold1", BLACK, 24'h0F0F0F, 24'hF0F0F0, 1'b1);
        bus.mode_i = MODE_ALWAYS;
        run_frame("f7_always", WHITE, 24'h123456, 24'hEDCBA9, 1'b0);
        bus.mode_i = MODE_NEVER;
        run_frame("f8_never", WHITE, 24'h123456, 24'h123456, 1'b1);
        bus.mode_i = MODE_AUTO;
        run_frame("f9_auto", WHITE, 24'h123456, 24'hEDCBA9, 1'b1);

        // Reset mid-frame while inverted: outputs drop without waiting for a clock.
        bus.vs_i = 1'b1;
        cycle();
        bus.vs_i = 1'b0;
        repeat (4) cycle();
        bus.de_i   = 1'b1;
        bus.live_i = WHITE;
        bus.dly_i  = 24'h123456;
        bus.hs_i   = 1'b1;
        bus.vs_i   = 1'b1;
        repeat (3) cycle();
        chk("midrst.pre", 32'(bus.data_o), 32'h00EDCBA9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        idle();
        cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        run_frame("f10_post", WHITE, 24'h123456, 24'h123456, 1'b0);
        run_frame("f11_post", WHITE, 24'h123456, 24'hEDCBA9, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
